door_sensor_conditioner: RTL and testbench
==========================================

Name: door_sensor_conditioner

Overview:
Upstream front end for door_controller. It synchronises and debounces the raw motion and obstacle sensor inputs. Motion becomes a single-cycle request pulse with re-trigger hold-off, and obstacle becomes a clean level. All outputs are registered and drive door_controller's motion_sensor and obstacle_sensor inputs directly.

Parameters:
DEB_CYCLES, 4, consecutive synchronised samples needed to accept a level change (>=1)
HOLDOFF_CYCLES, 16, cycles after a motion pulse during which motion is ignored (>=1)
STUCK_CYCLES, 1024, continuous obstacle-high cycles before a fault is flagged (>=2; used only with the optional feature)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
motion_raw  input  1  raw motion sensor, asynchronous to clk
obstacle_raw  input  1  raw obstacle sensor, asynchronous to clk
motion_level  output  1  debounced motion level
motion_pulse  output  1  one-cycle motion request to door_controller
obstacle_level  output  1  debounced obstacle level to door_controller
sensor_fault  output  1  sticky obstacle-stuck flag

Behaviour:
- One clock. Reset is asynchronous and active-high. All flops clear on rst assertion, with no clock needed.
- Reset values: all outputs 0, synchroniser flops 0, debounce counters 0, FSM in IDLE, hold-off and stuck counters 0.
- Synchroniser: a 2-flop chain per input. Nothing downstream reads the raw or first-stage flop.
- Debounce, per channel:
  - The stable value S drives the level output.
  - Counter behaviour: it increments while the synchronised sample differs from S and clears to 0 on any matching sample.
  - When the counter reaches DEB_CYCLES, S toggles on that edge and the counter clears.
  - Latency: the level output changes DEB_CYCLES+2 edges after the first edge that samples the new raw value.
  - A raw pulse or glitch shorter than DEB_CYCLES cycles never changes the level.
- Motion FSM (Moore):
  - IDLE: motion_level=1 -> PULSE.
  - PULSE: motion_pulse=1 for exactly one cycle, then unconditionally -> HOLDOFF.
  - HOLDOFF: counts HOLDOFF_CYCLES cycles, ignoring motion_level. At terminal count: motion_level=1 -> WAIT_LOW, else -> IDLE.
  - WAIT_LOW: motion_level=0 -> IDLE.
  - Result: at most one pulse per debounced rising episode, and pulses are at least HOLDOFF_CYCLES+1 cycles apart.
  - Pulse latency: high in the cycle after the edge where motion_level rises.
- obstacle_level has no hold-off and no FSM. It is a pure debounced level and is independent of the motion path.
- Simultaneous events: the motion and obstacle channels are fully independent. The block never suppresses or prioritises one over the other; door_controller owns priority.
- Reset mid-operation: everything returns to reset values immediately. If a raw input is high at reset release, it is re-qualified from scratch, and a motion pulse follows DEB_CYCLES+3 edges after release.
- Counter widths are $clog2(param+1). Counters saturate and never wrap.

Optional Feature:
Macro: SENSOR_STUCK_DET_EN.
- Defined:
  - A stuck counter increments while obstacle_level=1 and clears when obstacle_level=0. It saturates at STUCK_CYCLES.
  - sensor_fault sets to 1 on the edge where the count reaches STUCK_CYCLES and stays set until rst.
  - obstacle_level is unaffected, so the door stays held open, which is the safe state.
- Undefined: sensor_fault is tied to 0, the port remains, and no counter is synthesised.

Decomposition:
- Package door_sensor_pkg holds:
  - the motion FSM state enum (IDLE, PULSE, HOLDOFF, WAIT_LOW), 2 bits;
  - default constants for DEB_CYCLES, HOLDOFF_CYCLES and STUCK_CYCLES.
- Sub-module sensor_debounce: synchroniser plus debounce counter, parameterised by DEB_CYCLES, and instantiated twice (motion and obstacle).
- The top level holds the motion FSM, the hold-off counter and the optional stuck detector.

Test Plan:
(10 ns clock, DEB_CYCLES=4, HOLDOFF_CYCLES=16, STUCK_CYCLES=32.)
- Reset: assert rst for 2 cycles with both raw inputs high -> all outputs 0 during rst. After release, motion_level rises after 6 edges and motion_pulse is high for exactly 1 cycle on the 7th.
- Glitch rejection: motion_raw high for 3 cycles, then low -> motion_level and motion_pulse stay 0 throughout.
- Single press: motion_raw high for 40 cycles -> exactly one motion_pulse. The FSM reaches WAIT_LOW, and no further pulse occurs until motion_raw falls and rises again.
- Hold-off: two debounced presses whose rising edges are 10 cycles apart -> one pulse only. A third press whose level rises 20 cycles after the first pulse -> a second pulse.
- Obstacle: obstacle_raw toggles every cycle for 6 cycles, then holds high for 10 -> obstacle_level rises once, 6 edges after the stable-high start. On release it falls 6 edges later. Motion outputs are unaffected.
- Stuck detection (macro defined): obstacle_raw high for 50 cycles -> sensor_fault=1 on the 32nd cycle of obstacle_level high. It stays 1 after the release and clears only on rst. With the macro undefined, sensor_fault stays 0.

Source files
------------

// File: rtl/door_sensor_pkg.sv
// Shared types and default parameter values for the door sensor conditioner.
package door_sensor_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    HOLDOFF  = 2'd2,
    WAIT_LOW = 2'd3
  } motion_state_e;

  localparam int unsigned DEB_CYCLES_DEF     = 4;
  localparam int unsigned HOLDOFF_CYCLES_DEF = 16;
  localparam int unsigned STUCK_CYCLES_DEF   = 1024;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a consecutive-sample debounce counter.
// The accepted level toggles once DEB_CYCLES samples in a row disagree with it.
module sensor_debounce
  import door_sensor_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level_out
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = raw_in;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      // The sample being counted now is the DEB_CYCLES-th mismatch.
      if (cnt_q >= CW'(DEB_CYCLES - 1)) begin
        stable_d = ~stable_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level_out = stable_q;

endmodule

// File: rtl/door_sensor_conditioner.sv
// Conditions raw motion/obstacle sensors for door_controller: debounced levels,
// a held-off motion request pulse, and an optional sticky obstacle-stuck flag
// enabled by defining SENSOR_STUCK_DET_EN.
module door_sensor_conditioner
  import door_sensor_pkg::*;
#(
  parameter int unsigned DEB_CYCLES     = DEB_CYCLES_DEF,
  parameter int unsigned HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF,
  parameter int unsigned STUCK_CYCLES   = STUCK_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic motion_raw,
  input  logic obstacle_raw,
  output logic motion_level,
  output logic motion_pulse,
  output logic obstacle_level,
  output logic sensor_fault
);

  localparam int unsigned HW = $clog2(HOLDOFF_CYCLES + 1);

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_motion_deb (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (motion_raw),
    .level_out (motion_level)
  );

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_obstacle_deb (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (obstacle_raw),
    .level_out (obstacle_level)
  );

  motion_state_e state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          pulse_q, pulse_d;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = '0;
    case (state_q)
      IDLE:     if (motion_level) state_d = PULSE;
      PULSE:    state_d = HOLDOFF;
      HOLDOFF: begin
        if (hold_cnt_q >= HW'(HOLDOFF_CYCLES - 1)) begin
          state_d = motion_level ? WAIT_LOW : IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      WAIT_LOW: if (!motion_level) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // Pulse is registered alongside the state so the output is a clean flop.
    pulse_d = (state_d == PULSE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      pulse_q    <= pulse_d;
    end
  end

  assign motion_pulse = pulse_q;

`ifdef SENSOR_STUCK_DET_EN
  localparam int unsigned SW = $clog2(STUCK_CYCLES + 1);

  logic [SW-1:0] stuck_cnt_q, stuck_cnt_d;
  logic          fault_q, fault_d;

  always_comb begin
    stuck_cnt_d = '0;
    fault_d     = fault_q;
    if (obstacle_level) begin
      if (stuck_cnt_q < SW'(STUCK_CYCLES)) begin
        stuck_cnt_d = stuck_cnt_q + SW'(1);
      end else begin
        stuck_cnt_d = stuck_cnt_q;
      end
      if (stuck_cnt_d == SW'(STUCK_CYCLES)) fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stuck_cnt_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      stuck_cnt_q <= stuck_cnt_d;
      fault_q     <= fault_d;
    end
  end

  assign sensor_fault = fault_q;
`else
  assign sensor_fault = 1'b0 && (STUCK_CYCLES != 0);
`endif

endmodule

// File: tb/tb_door_sensor_conditioner.sv
// Self-checking bench for door_sensor_conditioner: directed scenarios plus
// randomized sensor activity compared against a time-window reference model.
module tb_door_sensor_conditioner;

  localparam int unsigned DEB   = 4;
  localparam int unsigned HOLD  = 16;
  localparam int unsigned STUCK = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic motion_raw, obstacle_raw;
  logic motion_level, motion_pulse, obstacle_level, sensor_fault;

  always #5 clk = ~clk;

  door_sensor_conditioner #(
    .DEB_CYCLES     (DEB),
    .HOLDOFF_CYCLES (HOLD),
    .STUCK_CYCLES   (STUCK)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .motion_raw     (motion_raw),
    .obstacle_raw   (obstacle_raw),
    .motion_level   (motion_level),
    .motion_pulse   (motion_pulse),
    .obstacle_level (obstacle_level),
    .sensor_fault   (sensor_fault)
  );

  // Reference model: raw sample history per channel, newest first.
  bit mq[$];
  bit oq[$];
  bit m_lvl, o_lvl, m_pulse, m_fault;
  bit blocked, wait_low;
  int n, decide, run;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Level flips when the last DEB synchronised samples (raw two edges back) all disagree.
  function automatic bit deb_next(input bit q[$], input bit lvl);
    bit all_diff = 1'b1;
    for (int i = 0; i < DEB; i++) if (q[2 + i] == lvl) all_diff = 1'b0;
    return all_diff ? ~lvl : lvl;
  endfunction

  task automatic model_reset();
    mq = {};
    oq = {};
    repeat (DEB + 2) begin
      mq.push_back(1'b0);
      oq.push_back(1'b0);
    end
    m_lvl = 0; o_lvl = 0; m_pulse = 0; m_fault = 0;
    blocked = 0; wait_low = 0; n = 0; decide = 0; run = 0;
  endtask

  task automatic model_edge();
    bit old_m, old_o;
    n++;
    old_m = m_lvl;
    old_o = o_lvl;
    mq.push_front(motion_raw);   void'(mq.pop_back());
    oq.push_front(obstacle_raw); void'(oq.pop_back());
    m_lvl = deb_next(mq, old_m);
    o_lvl = deb_next(oq, old_o);

    // A pulse opens a window of HOLD+1 edges; at its end a still-high level must drop first.
    m_pulse = 1'b0;
    if (!blocked) begin
      if (old_m) begin
        m_pulse  = 1'b1;
        blocked  = 1'b1;
        wait_low = 1'b0;
        decide   = n + HOLD + 1;
      end
    end else if (!wait_low) begin
      if (n == decide) begin
        if (old_m) wait_low = 1'b1;
        else       blocked  = 1'b0;
      end
    end else if (!old_m) begin
      wait_low = 1'b0;
      blocked  = 1'b0;
    end

`ifdef SENSOR_STUCK_DET_EN
    if (old_o) begin
      if (run < STUCK) run++;
      if (run == STUCK) m_fault = 1'b1;
    end else begin
      run = 0;
    end
`else
    m_fault = 1'b0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    check("motion_level",   motion_level,   m_lvl);
    check("motion_pulse",   motion_pulse,   m_pulse);
    check("obstacle_level", obstacle_level, o_lvl);
    check("sensor_fault",   sensor_fault,   m_fault);
  endtask

  task automatic drive(input bit m, input bit o, input int cycles);
    motion_raw   = m;
    obstacle_raw = o;
    repeat (cycles) tick();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_async_motion_level",   motion_level,   1'b0);
    check("rst_async_motion_pulse",   motion_pulse,   1'b0);
    check("rst_async_obstacle_level", obstacle_level, 1'b0);
    check("rst_async_sensor_fault",   sensor_fault,   1'b0);
    repeat (cycles) tick();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    motion_raw   = 1'b1;
    obstacle_raw = 1'b1;
    #2;
    // Reset with both inputs high, then re-qualification after release.
    do_reset(2);
    drive(1, 1, 10);
    drive(0, 0, 30);
    // Glitch shorter than the debounce window.
    drive(1, 0, 3);
    drive(0, 0, 20);
    // Single long press.
    drive(1, 0, 40);
    drive(0, 0, 20);
    // Two presses 10 cycles apart, then a third well after the hold-off.
    drive(1, 0, 6);
    drive(0, 0, 4);
    drive(1, 0, 6);
    drive(0, 0, 14);
    drive(1, 0, 8);
    drive(0, 0, 30);
    // Obstacle chatter then a stable level.
    for (int i = 0; i < 6; i++) drive(0, 1'(i % 2), 1);
    drive(0, 1, 10);
    drive(0, 0, 15);
    // Obstacle held long enough to trip the stuck detector.
    drive(0, 1, 50);
    drive(0, 0, 20);
    // Reset while both channels are active.
    drive(1, 1, 3);
    do_reset(3);
    drive(1, 0, 12);
    drive(0, 0, 20);
    // Randomized activity on both channels.
    repeat (60) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 24)));
    end
    drive(0, 1, 40);
    drive(0, 0, 10);
    do_reset(2);
    drive(0, 0, 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
